block_cipher_core: RTL and testbench

//  Iterative 64-bit block encryption stage directly downstream of the msg/key assembler.

---
 rtl/block_cipher_core.sv | 111 +++++++++++
 tb/tb_block_cipher_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_cipher_core.sv
// Iterative 64-bit block cipher, one round per clock.
// Captures a (msg, key) pair on the rising edge of in_ready.
module block_cipher_core #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_msg,
    input  logic [63:0] in_key,
    input  logic        in_ready,
    output logic [63:0] ct,
    output logic        ct_valid,
    input  logic        ct_ack,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
        $error("ROUNDS out of range 1..64");
    end

    logic [1:0]  state;
    logic [63:0] s;
    logic [63:0] key;
    logic [7:0]  r;
    logic        ready_d;
    logic        rise;
    logic [63:0] rk;
    logic [63:0] s_next;

    function automatic logic [63:0] rotl64(
        input logic [63:0] x,
        input logic [5:0]  n
    );
        // A zero amount yields x >> 64 == 0, so no special case.
        return (x << n) | (x >> (7'd64 - {1'b0, n}));
    endfunction

    assign rise = in_ready & ~ready_d;

    always_comb begin
        rk     = rotl64(key, r[5:0]) ^ {56'b0, r};
        s_next = rotl64(s ^ rk, 6'd3) + rk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            key      <= '0;
            r        <= '0;
            ready_d  <= 1'b0;
            ct       <= '0;
            ct_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ready_d <= in_ready;
            case (state)
                IDLE: begin
                    if (rise) begin
                        s     <= in_msg;
                        key   <= in_key;
                        r     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    s <= s_next;
                    r <= r + 8'd1;
                    if (r == LAST) begin
                        ct       <= s_next;
                        ct_valid <= 1'b1;
                        state    <= HOLD;
                    end
                    if (rise) begin
                        overrun <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ct_ack) begin
                        ct_valid <= 1'b0;
                        // Ack and a new pair on the same edge: start the next block.
                        if (rise) begin
                            s     <= in_msg;
                            key   <= in_key;
                            r     <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_cipher_core.sv
// Scoreboard bench for block_cipher_core with ROUNDS = 1, 2 and 16.
// Instance 0: ROUNDS=1, instance 1: ROUNDS=2, instance 2: ROUNDS=16.
module tb_block_cipher_core;

    logic        clk;
    logic        rst;
    logic [63:0] in_msg;
    logic [63:0] in_key;
    logic        in_ready [3];
    logic        ct_ack   [3];
    logic [63:0] ct_o     [3];
    logic        ct_valid [3];
    logic        busy     [3];
    logic        overrun  [3];

    int checks;
    int errors;
    int cyc;

    typedef struct {
        int          inst;
        logic [63:0] ct;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        block_cipher_core #(
            .ROUNDS(g == 0 ? 1 : (g == 1 ? 2 : 16))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .in_msg  (in_msg),
            .in_key  (in_key),
            .in_ready(in_ready[g]),
            .ct      (ct_o[g]),
            .ct_valid(ct_valid[g]),
            .ct_ack  (ct_ack[g]),
            .busy    (busy[g]),
            .overrun (overrun[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int rounds_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 16);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[62:0], y[63]};
        return y;
    endfunction

    function automatic logic [63:0] model(
        input logic [63:0] m,
        input logic [63:0] k,
        input int          nr
    );
        logic [63:0] st;
        logic [63:0] rkv;
        st = m;
        for (int r = 0; r < nr; r++) begin
            rkv = rotl(k, r) ^ 64'(r);
            st  = rotl(st ^ rkv, 3) + rkv;
        end
        return st;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push(input int g, input logic [63:0] v, input int at);
        exp_t e;
        e.inst = g;
        e.ct   = v;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Called at a negedge: pulse in_ready for one cycle and expect v.
    task automatic issue(input int g, input logic [63:0] m, input logic [63:0] k,
                         input logic [63:0] v);
        in_msg      = m;
        in_key      = k;
        in_ready[g] = 1'b1;
        push(g, v, cyc + 1 + rounds_of(g));
        @(negedge clk);
        in_ready[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g);
        int n;
        n = 0;
        while (ct_valid[g] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ct_valid[g] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid inst=%0d timed out after %0d cycles", g, n);
        end
    endtask

    task automatic ack(input int g);
        ct_ack[g] = 1'b1;
        @(negedge clk);
        ct_ack[g] = 1'b0;
    endtask

    logic        vprev  [3];
    logic [63:0] ctprev [3];

    initial begin
        for (int g = 0; g < 3; g++) begin
            vprev[g]  = 1'b0;
            ctprev[g] = '0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ct_valid[g] === 1'b1 && vprev[g] !== 1'b1) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].inst == g) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_ct inst=%0d got=%h want=none", g, ct_o[g]);
                end else begin
                    if (ct_o[g] !== sb[idx].ct || cyc != sb[idx].cyc) begin
                        errors++;
                        $display("FAIL sb_ct inst=%0d got=%h@%0d want=%h@%0d",
                                 g, ct_o[g], cyc, sb[idx].ct, sb[idx].cyc);
                    end
                    sb.delete(idx);
                end
            end else if (ct_valid[g] === 1'b1) begin
                checks++;
                if (ct_o[g] !== ctprev[g]) begin
                    errors++;
                    $display("FAIL hold_stable inst=%0d got=%h want=%h", g, ct_o[g], ctprev[g]);
                end
            end
            vprev[g]  = ct_valid[g];
            ctprev[g] = ct_o[g];
        end
    end

    initial begin
        logic [63:0] m;
        logic [63:0] k;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        in_msg = '0;
        in_key = '0;
        for (int g = 0; g < 3; g++) begin
            in_ready[g] = 1'b0;
            ct_ack[g]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("rst_ct", ct_o[g], 64'h0);
            chk("rst_valid", {63'b0, ct_valid[g]}, 64'h0);
            chk("rst_busy", {63'b0, busy[g]}, 64'h0);
            chk("rst_overrun", {63'b0, overrun[g]}, 64'h0);
        end

        issue(0, 64'h1, 64'h0, 64'h8);
        wait_valid(0);
        chk("t1_busy_hold", {63'b0, busy[0]}, 64'h1);
        ack(0);
        chk("t1_valid_after_ack", {63'b0, ct_valid[0]}, 64'h0);
        chk("t1_busy_after_ack", {63'b0, busy[0]}, 64'h0);
        chk("t1_ct_kept", ct_o[0], 64'h8);

        issue(0, 64'h0, 64'h1, 64'h9);
        wait_valid(0);
        ack(0);
        issue(1, 64'h0, 64'h0, 64'h9);
        wait_valid(1);
        ack(1);

        m = 64'h0123_4567_89AB_CDEF;
        k = 64'hFEDC_BA98_7654_3210;
        issue(2, m, k, model(m, k, 16));
        wait_valid(2);
        repeat (20) @(negedge clk);
        chk("t3_valid_held", {63'b0, ct_valid[2]}, 64'h1);
        ack(2);
        chk("t3_valid_cleared", {63'b0, ct_valid[2]}, 64'h0);
        ct_ack[2] = 1'b1;
        repeat (2) @(negedge clk);
        ct_ack[2] = 1'b0;
        chk("idle_ack_busy", {63'b0, busy[2]}, 64'h0);
        chk("idle_ack_valid", {63'b0, ct_valid[2]}, 64'h0);

        m = 64'hDEAD_BEEF_0000_0001;
        k = 64'h0000_0000_CAFE_F00D;
        issue(2, m, k, model(m, k, 16));
        repeat (3) @(negedge clk);
        in_msg      = 64'h5555_5555_5555_5555;
        in_key      = 64'hAAAA_AAAA_AAAA_AAAA;
        in_ready[2] = 1'b1;
        @(negedge clk);
        in_ready[2] = 1'b0;
        chk("t4_overrun", {63'b0, overrun[2]}, 64'h1);
        wait_valid(2);
        ack(2);
        repeat (25) @(negedge clk);
        chk("t4_no_second", {63'b0, busy[2]}, 64'h0);
        chk("t4_overrun_sticky", {63'b0, overrun[2]}, 64'h1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_overrun_cleared", {63'b0, overrun[2]}, 64'h0);
        m = 64'h1111_2222_3333_4444;
        k = 64'h9999_8888_7777_6666;
        issue(2, m, k, model(m, k, 16));
        wait_valid(2);
        m = 64'h0F0F_0F0F_F0F0_F0F0;
        k = 64'h1234_0000_0000_4321;
        in_msg      = m;
        in_key      = k;
        in_ready[2] = 1'b1;
        ct_ack[2]   = 1'b1;
        push(2, model(m, k, 16), cyc + 1 + 16);
        @(negedge clk);
        in_ready[2] = 1'b0;
        ct_ack[2]   = 1'b0;
        chk("t5_valid_dropped", {63'b0, ct_valid[2]}, 64'h0);
        chk("t5_busy", {63'b0, busy[2]}, 64'h1);
        wait_valid(2);
        chk("t5_overrun", {63'b0, overrun[2]}, 64'h0);
        ack(2);

        in_msg      = 64'h7777_0000_7777_0000;
        in_ready[2] = 1'b1;
        @(negedge clk);
        in_ready[2] = 1'b0;
        repeat (5) @(negedge clk);
        m = 64'hABCD_EF01_2345_6789;
        k = 64'h0000_FFFF_0000_FFFF;
        in_msg      = m;
        in_key      = k;
        in_ready[2] = 1'b1;
        rst         = 1'b1;
        @(negedge clk);
        chk("t6_rst_ct", ct_o[2], 64'h0);
        chk("t6_rst_valid", {63'b0, ct_valid[2]}, 64'h0);
        chk("t6_rst_busy", {63'b0, busy[2]}, 64'h0);
        chk("t6_rst_overrun", {63'b0, overrun[2]}, 64'h0);
        rst = 1'b0;
        push(2, model(m, k, 16), cyc + 1 + 16);
        wait_valid(2);
        ack(2);
        repeat (25) @(negedge clk);
        chk("t6_single_block", {63'b0, busy[2]}, 64'h0);
        in_ready[2] = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            m = {$urandom, $urandom};
            k = {$urandom, $urandom};
            issue(2, m, k, model(m, k, 16));
            wait_valid(2);
            ack(2);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
